// File: rtl/jtag_debug_host_pkg.sv
// Shared encodings and sequencing helpers for the JTAG debug host.
package jtag_debug_host_pkg;

  localparam int DR_MAX_DEFAULT = 38;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00,
    OP_SHIFT_IR  = 2'b01,
    OP_SHIFT_DR  = 2'b10,
    OP_IDLE      = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_e;

  // One TCK worth of sequencing: TMS level and, for data TCKs, the bit index.
  typedef struct packed {
    logic       tms;
    logic       is_data;
    logic [6:0] didx;
  } step_t;

  // IEEE 1149.1 TAP controller transition on a TCK rising edge.
  function automatic tap_e tap_next(tap_e s, logic tms);
    tap_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
      default:    n = TAP_TLR;
    endcase
    return n;
  endfunction

  // Total TCKs a (non-empty) command occupies, including the optional TLR escape.
  function automatic logic [6:0] seq_total(op_e op, logic [5:0] len, logic pre);
    logic [6:0] t;
    case (op)
      OP_TAP_RESET: t = 7'd6;
      OP_SHIFT_IR:  t = 7'd6 + {1'b0, len} + {6'd0, pre};
      OP_SHIFT_DR:  t = 7'd5 + {1'b0, len} + {6'd0, pre};
      default:      t = {1'b0, len} + {6'd0, pre};
    endcase
    return t;
  endfunction

  // TMS / data role of TCK number j within a command.
  function automatic step_t seq_step(op_e op, logic [5:0] len, logic pre, logic [6:0] j);
    step_t      st;
    logic [6:0] k, l, hdr;
    st  = '0;
    l   = {1'b0, len};
    k   = j - {6'd0, pre};
    hdr = (op == OP_SHIFT_IR) ? 7'd4 : 7'd3;
    if (op == OP_TAP_RESET) begin
      st.tms = (j < 7'd5);
    end else if (pre && (j == 7'd0)) begin
      st.tms = 1'b0;
    end else if (op == OP_IDLE) begin
      st.tms = 1'b0;
    end else if (k < hdr) begin
      // IR header 1,1,0,0; DR header 1,0,0
      st.tms = (op == OP_SHIFT_IR) ? (k < 7'd2) : (k == 7'd0);
    end else if (k < hdr + l) begin
      st.is_data = 1'b1;
      st.didx    = k - hdr;
      st.tms     = (k == hdr + l - 7'd1);
    end else begin
      // Update (TMS=1) then back to Run-Test/Idle (TMS=0)
      st.tms = (k == hdr + l);
    end
    return st;
  endfunction

endpackage

// File: rtl/jtag_debug_host_tckgen.sv
// TCK generator: CLK_DIV clks low then CLK_DIV clks high while enabled.
// rise_stb marks the clk cycle whose closing edge raises tck;
// fall_stb marks the cycle whose closing edge ends the high phase.
module jtag_debug_host_tckgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       wrap;

  assign wrap     = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise_stb = wrap && !tck_q;
  assign fall_stb = wrap && tck_q;
  assign tck      = tck_q;

  // Phase counter; collapses to a low, zero-count idle when disabled.
  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en) begin
      if (wrap) begin
        cnt_d = '0;
        tck_d = !tck_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
        tck_d = tck_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_debug_host.sv
// JTAG debug host: accepts TAP_RESET / SHIFT_IR / SHIFT_DR / IDLE_CYCLES
// commands and sequences TMS/TDI against a tracked TAP state.
module jtag_debug_host
  import jtag_debug_host_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DR_MAX  = DR_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  logic              busy_q, busy_d;
  logic              rdy_en_q, rdy_en_d;
  op_e               op_q, op_d;
  logic [5:0]        len_q, len_d;
  logic [DR_MAX-1:0] data_q, data_d;
  logic              pre_q, pre_d;
  logic [6:0]        idx_q, idx_d;
  logic [6:0]        total_q, total_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic [DR_MAX-1:0] cap_q, cap_d;
  logic [DR_MAX-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  tap_e              tap_q, tap_d;

  logic              fall_stb, rise_stb;
  logic              accept;
  op_e               op_c;
  logic [5:0]        len_c;
  logic              pre_c, zero_c;
  step_t             st_acc, st_cur, st_nxt;
  logic [DR_MAX-1:0] acc_sh, nxt_sh;

  jtag_debug_host_tckgen #(.CLK_DIV(CLK_DIV)) u_tckgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (busy_q),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  assign cmd_ready = rdy_en_q && !busy_q;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = busy_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Command decode at accept: clamp length, decide on the TLR escape TCK.
  assign op_c   = op_e'(cmd_op);
  assign len_c  = (cmd_len > 6'(DR_MAX)) ? 6'(DR_MAX) : cmd_len;
  assign zero_c = (op_c != OP_TAP_RESET) && (len_c == 6'd0);
  assign pre_c  = (tap_q == TAP_TLR) && (op_c != OP_TAP_RESET) && !zero_c;
  assign st_acc = seq_step(op_c, len_c, pre_c, 7'd0);
  assign st_cur = seq_step(op_q, len_q, pre_q, idx_q);
  assign st_nxt = seq_step(op_q, len_q, pre_q, idx_q + 7'd1);
  assign acc_sh = cmd_data >> st_acc.didx;
  assign nxt_sh = data_q >> st_nxt.didx;

  // Sequencer: first TCK set up at accept, later TCKs at each high-phase end.
  always_comb begin
    busy_d      = busy_q;
    rdy_en_d    = 1'b1;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    pre_d       = pre_q;
    idx_d       = idx_q;
    total_d     = total_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    tap_d       = tap_q;
    if (accept) begin
      if (zero_c) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
      end else begin
        busy_d  = 1'b1;
        op_d    = op_c;
        len_d   = len_c;
        data_d  = cmd_data;
        pre_d   = pre_c;
        idx_d   = 7'd0;
        total_d = seq_total(op_c, len_c, pre_c);
        cap_d   = '0;
        tms_d   = st_acc.tms;
        tdi_d   = st_acc.is_data && acc_sh[0];
      end
    end else if (busy_q) begin
      if (rise_stb) begin
        tap_d = tap_next(tap_q, tms_q);
        if (st_cur.is_data)
          cap_d = cap_q | ({{(DR_MAX-1){1'b0}}, tdo} << st_cur.didx);
      end
      if (fall_stb) begin
        if (idx_q == total_q - 7'd1) begin
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end else begin
          idx_d = idx_q + 7'd1;
          tms_d = st_nxt.tms;
          tdi_d = st_nxt.is_data && nxt_sh[0];
        end
      end
    end
  end

  // State registers; reset parks the TAP view in Test-Logic-Reset with TMS high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
      op_q        <= OP_TAP_RESET;
      len_q       <= '0;
      data_q      <= '0;
      pre_q       <= 1'b0;
      idx_q       <= '0;
      total_q     <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      tap_q       <= TAP_TLR;
    end else begin
      busy_q      <= busy_d;
      rdy_en_q    <= rdy_en_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      tap_q       <= tap_d;
    end
  end

endmodule

// File: tb/tb_jtag_debug_host.sv
// Directed bench for jtag_debug_host with a small target TAP model.
module tb_jtag_debug_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = 6'd0;
  logic [37:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [37:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic        tms_log[$];
  logic        tdi_log[$];
  int          rsp_count = 0;
  logic        loopback = 1'b0;
  int          lat;
  logic        b1, r1;

  always #5 clk = ~clk;

  jtag_debug_host dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // Target TAP: IR captures 01, shifts on Shift-IR, TDO launched on TCK fall.
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } ts_e;
  ts_e         ts;
  logic [37:0] ir_sr;
  logic        tdo_r;

  function automatic ts_e t_next(ts_e s, logic m);
    case (s)
      T_TLR:  return m ? T_TLR : T_RTI;
      T_RTI:  return m ? T_SDR : T_RTI;
      T_SDR:  return m ? T_SIR : T_CDR;
      T_CDR, T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR : T_SHDR;
      T_SIR:  return m ? T_TLR : T_CIR;
      T_CIR, T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR : T_SHIR;
      default: return m ? T_SDR : T_RTI; // Update-DR / Update-IR
    endcase
  endfunction

  always @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      ts    <= T_TLR;
      ir_sr <= '0;
    end else begin
      if (ts == T_CIR) ir_sr <= 38'h1;
      else if (ts == T_SHIR) ir_sr <= {tdi, ir_sr[37:1]};
      ts <= t_next(ts, tms);
    end
  end

  always @(negedge tck or negedge reset_n) begin
    if (!reset_n) tdo_r <= 1'b0;
    else tdo_r <= (ts == T_SHIR) ? ir_sr[0] : 1'b0;
  end

  assign tdo = loopback ? tdi : tdo_r;

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
  end

  always @(posedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tms_bits();
    logic [63:0] v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_bits();
    logic [63:0] v = '0;
    for (int i = 0; i < tdi_log.size() && i < 64; i++) v[i] = tdi_log[i];
    return v;
  endfunction

  // Issue one command, scramble inputs while busy, wait (bounded) for rsp.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [37:0] data, input logic [37:0] exp_rsp);
    int n;
    logic [37:0] e;
    exp_q.push_back(exp_rsp);
    tms_log.delete();
    tdi_log.delete();
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len; cmd_data = ~data;
    b1 = busy; r1 = cmd_ready;
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    check({tag, "_rsp_seen"}, {63'd0, rsp_valid}, 64'd1);
    if (rsp_valid) begin
      check({tag, "_busy_at_rsp"}, {63'd0, busy}, 64'd0);
      e = exp_q.pop_front();
      check({tag, "_rsp_data"}, {26'd0, rsp_data}, {26'd0, e});
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  int rc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tck", {63'd0, tck}, 64'd0);
    check("rst_tms", {63'd0, tms}, 64'd1);
    check("rst_tdi", {63'd0, tdi}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {26'd0, rsp_data}, 64'd0);
    reset_n = 1'b1;
    #1 check("ready_before_edge", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_release", {63'd0, cmd_ready}, 64'd1);

    // TAP_RESET: 6 TCKs, TMS 1,1,1,1,1,0, 4 clks per TCK
    run_cmd("tap_reset", 2'b00, 6'd0, 38'h0, 38'h0);
    check("tap_reset_busy_after_accept", {62'd0, b1, r1}, 64'b10);
    check("tap_reset_tcks", tms_log.size(), 64'd6);
    check("tap_reset_tms", tms_bits(), 64'h1F);
    check("tap_reset_lat_in_window", {63'd0, (lat >= 24 && lat <= 26)}, 64'd1);
    check("tap_reset_target_rti", {60'd0, ts}, {60'd0, T_RTI});

    // SHIFT_IR len=2, data 2'b10, target captures 01
    loopback = 1'b0;
    run_cmd("shift_ir", 2'b01, 6'd2, 38'h2, 38'h1);
    check("shift_ir_tcks", tms_log.size(), 64'd8);
    check("shift_ir_tms", tms_bits(), 64'h63);
    check("shift_ir_tdi", tdi_bits(), 64'h20);
    check("shift_ir_lat", lat, 64'd33);

    // SHIFT_DR len=38 loopback
    loopback = 1'b1;
    run_cmd("shift_dr38", 2'b10, 6'd38, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA);
    check("shift_dr38_tcks", tms_log.size(), 64'd43);
    check("shift_dr38_tms", tms_bits(), 64'h0000_0300_0000_0001);

    // SHIFT_DR len=63 clamps to 38
    run_cmd("shift_dr63", 2'b10, 6'd63, 38'h15_AAAA_5555, 38'h15_AAAA_5555);
    check("shift_dr63_tcks", tms_log.size(), 64'd43);

    // SHIFT_DR len=0: no TCK, response the cycle after accept
    run_cmd("shift_dr0", 2'b10, 6'd0, 38'h3F_FFFF_FFFF, 38'h0);
    check("shift_dr0_tcks", tms_log.size(), 64'd0);
    check("shift_dr0_lat", lat, 64'd1);

    // IDLE_CYCLES len=5 and len=0
    run_cmd("idle5", 2'b11, 6'd5, 38'h3F_FFFF_FFFF, 38'h0);
    check("idle5_tcks", tms_log.size(), 64'd5);
    check("idle5_tms_tdi", {tms_bits()[31:0], tdi_bits()[31:0]}, 64'd0);
    check("idle5_lat", lat, 64'd21);
    run_cmd("idle0", 2'b11, 6'd0, 38'h1, 38'h0);
    check("idle0_lat", lat, 64'd1);

    // SHIFT_DR straight after reset: escape TCK from Test-Logic-Reset first
    do_reset();
    run_cmd("dr_after_rst", 2'b10, 6'd4, 38'h3F_FFFF_FFFB, 38'hB);
    check("dr_after_rst_tcks", tms_log.size(), 64'd10);
    check("dr_after_rst_tms", tms_bits(), 64'h182);
    check("dr_after_rst_tdi", tdi_bits(), 64'hB0);

    // Reset during the 10th TCK of a 38-bit SHIFT_DR
    tms_log.delete();
    tdi_log.delete();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd38; cmd_data = 38'h12_3456_789A;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rc = 0;
    while (tms_log.size() < 10 && rc < 400) begin @(negedge clk); rc++; end
    check("abort_reached_tck10", tms_log.size(), 64'd10);
    rc = rsp_count;
    reset_n = 1'b0;
    #1;
    check("abort_tck", {63'd0, tck}, 64'd0);
    check("abort_tms", {63'd0, tms}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", {63'd0, cmd_ready}, 64'd1);
    repeat (200) @(negedge clk);
    check("abort_no_rsp", rsp_count, rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_debug_host.md
JTAG_DEBUG_HOST -- requirements
Module: jtag_debug_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: TCK half-period in clk cycles, legal values 1..255.
REQ-002 SHALL have parameter DR_MAX, default 38: maximum shift length, matching the 38-bit debug data register.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have these ports:
  - clk  in  1  system clock.
  - reset_n  in  1  asynchronous active-low reset.
  - cmd_valid  in  1  command offered.
  - cmd_ready  out  1  command accepted when cmd_valid is also high.
  - cmd_op  in  2  command: 00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE_CYCLES.
  - cmd_len  in  6  bit count for shifts; TCK count for IDLE_CYCLES.
  - cmd_data  in  38  TDI bits, LSB shifted first.
  - rsp_valid  out  1  one-cycle completion pulse.
  - rsp_data  out  38  captured TDO bits.
  - busy  out  1  command in progress.
  - tck  out  1  JTAG clock.
  - tms  out  1  JTAG mode select.
  - tdi  out  1  JTAG data to target.
  - tdo  in  1  JTAG data from target.

Function
REQ-005 SHALL generate each TCK period as CLK_DIV clk cycles low followed by CLK_DIV clk cycles high; tck SHALL idle low when not busy.
REQ-006 SHALL update tms/tdi only at the start of a TCK low phase, and SHALL sample tdo on the clk cycle in which tck rises.
REQ-007 SHALL assert cmd_ready exactly when busy is low; the accept cycle is the cycle with cmd_valid and cmd_ready both high; busy SHALL rise on the next cycle.
REQ-008 SHALL track all 16 IEEE 1149.1 TAP states internally; after each TCK rising edge the tracked state SHALL equal the state reached by the target TAP.
REQ-009 TAP_RESET SHALL drive 5 TCKs with TMS=1 and then 1 TCK with TMS=0, ending in Run-Test/Idle (6 TCKs total).
REQ-010 SHIFT_IR SHALL drive the following sequence from Run-Test/Idle (total 6+len TCKs):
  - TMS 1,1,0,0 to reach Shift-IR.
  - len data TCKs with TMS=0, except the last data TCK with TMS=1 (to Exit1-IR).
  - TMS 1 (Update-IR), then TMS 0 (Run-Test/Idle).
REQ-011 SHIFT_DR SHALL drive the following sequence from Run-Test/Idle (total 5+len TCKs):
  - TMS 1,0,0 to reach Shift-DR.
  - len data TCKs as in REQ-010.
  - TMS 1 (Update-DR), then TMS 0 (Run-Test/Idle).
REQ-012 IDLE_CYCLES SHALL drive len TCKs with TMS=0 and TDI=0.
REQ-013 SHALL drive tdi = cmd_data[i] during the i-th data TCK; tdi SHALL be 0 during non-data TCKs.
REQ-014 SHALL set rsp_data[i] to the tdo sampled on the i-th data TCK, with bits at index >= len set to 0.
REQ-015 SHALL hold rsp_data stable from the rsp_valid pulse until the next accept.
REQ-016 SHALL pulse rsp_valid for one cycle after the last TCK high phase ends; busy SHALL fall in that same cycle.
REQ-017 A SHIFT_IR or SHIFT_DR with cmd_len=0 SHALL produce no TCK and SHALL pulse rsp_valid with rsp_data=0 on the cycle after accept.
REQ-018 IDLE_CYCLES with cmd_len=0 SHALL behave as in REQ-017.
REQ-019 SHALL clamp cmd_len > DR_MAX to DR_MAX.
REQ-020 If the tracked state is Test-Logic-Reset when a SHIFT_IR, SHIFT_DR or IDLE_CYCLES command is accepted, SHALL prepend one TCK with TMS=0.
REQ-021 SHALL latch cmd_op, cmd_len and cmd_data at accept; input changes while busy SHALL have no effect.

Reset
REQ-022 While reset_n is low SHALL force:
  - tck=0, tms=1, tdi=0;
  - busy=0, cmd_ready=0, rsp_valid=0, rsp_data=0;
  - tracked TAP state = Test-Logic-Reset.
REQ-023 cmd_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-024 Reset asserted mid-command SHALL abort the command; no rsp_valid SHALL be produced for it.

Structure
REQ-025 Package jtag_debug_host_pkg SHALL hold the cmd_op encoding, the 16-state TAP enum, and the default DR_MAX.
REQ-026 Sub-module jtag_debug_host_tckgen SHALL generate the tck level plus single-cycle fall/rise strobes from CLK_DIV; the sequencer SHALL use only those strobes.

Verification
REQ-027 Reset, then TAP_RESET: 6 TCKs with TMS 1,1,1,1,1,0; with CLK_DIV=2 each TCK spans 4 clks; rsp_valid 24..26 clks after accept.
REQ-028 SHIFT_IR len=2, data=2'b10: 8 TCKs; TMS=1,1,0,0,0,1,1,0; tdi on the two data TCKs = 0 then 1; target model returns IR capture 01 -> rsp_data=38'h1.
REQ-029 SHIFT_DR len=38, data=38'h2A_5555_AAAA with loopback tdo=tdi -> 43 TCKs and rsp_data=38'h2A_5555_AAAA.
REQ-030 SHIFT_DR len=63 -> clamped to 38 (43 TCKs); SHIFT_DR len=0 -> no TCK edge, rsp_valid on the cycle after accept, rsp_data=0.
REQ-031 SHIFT_DR issued directly after reset (tracked state Test-Logic-Reset), len=4 -> one extra TMS=0 TCK first, 10 TCKs total.
REQ-032 reset_n pulsed low during the 10th TCK of a 38-bit SHIFT_DR -> tck=0, tms=1 immediately; no rsp_valid; cmd_ready=1 one clk after release.
